// File: rtl/csa_mac_accumulator.sv
// MAC back-end: resolves redundant (pp1, pp2) product pairs and accumulates them
// per group, emitting a signed sum, a saturating beat count and a sticky overflow flag.
module csa_mac_accumulator #(
   parameter int N     = 5,
   parameter int M     = 5,
   parameter int ACC_W = 24,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N+M-1:0]     pp1,
   input  logic [N+M-1:0]     pp2,
   input  logic               in_clear,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   acc_out,
   output logic [CNT_W-1:0]   cnt_out,
   output logic               ovf_out
);

   localparam int P = N + M;

   logic             s1_valid_q, s1_valid_d;
   logic [P-1:0]     s1_p_q, s1_p_d;
   logic             s1_clear_q, s1_clear_d;
   logic             s1_last_q, s1_last_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             group_done_q, group_done_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
   logic             ovf_out_q, ovf_out_d;

   logic             s1_advance;
   logic             accept;
   logic             fresh;
   logic [ACC_W-1:0] p_ext;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] sum;
   logic             add_ovf;
   logic             ovf_next;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_next;

   // A last beat may only leave S1 if the result registers are free or being drained.
   assign s1_advance = s1_valid_q & ~(s1_last_q & out_valid_q & ~out_ready);
   assign in_ready   = ~s1_valid_q | s1_advance;
   assign accept     = in_valid & in_ready;

   assign fresh    = s1_clear_q | group_done_q;
   assign p_ext    = ACC_W'($signed(s1_p_q));
   assign base     = fresh ? '0 : acc_q;
   assign sum      = base + p_ext;
   assign add_ovf  = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
   assign ovf_next = (fresh ? 1'b0 : ovf_q) | add_ovf;
   assign cnt_base = fresh ? '0 : cnt_q;
   assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_p_d       = s1_p_q;
      s1_clear_d   = s1_clear_q;
      s1_last_d    = s1_last_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      group_done_d = group_done_q;
      out_valid_d  = out_valid_q;
      acc_out_d    = acc_out_q;
      cnt_out_d    = cnt_out_q;
      ovf_out_d    = ovf_out_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_p_d     = pp1 + pp2;
         s1_clear_d = in_clear;
         s1_last_d  = in_last;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      if (s1_advance) begin
         if (s1_last_q) begin
            out_valid_d  = 1'b1;
            acc_out_d    = sum;
            cnt_out_d    = cnt_next;
            ovf_out_d    = ovf_next;
            group_done_d = 1'b1;
         end else begin
            acc_d        = sum;
            cnt_d        = cnt_next;
            ovf_d        = ovf_next;
            group_done_d = 1'b0;
         end
      end
   end

   // group_done comes out of reset set so the first beat starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_p_q       <= '0;
         s1_clear_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         group_done_q <= 1'b1;
         out_valid_q  <= 1'b0;
         acc_out_q    <= '0;
         cnt_out_q    <= '0;
         ovf_out_q    <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_p_q       <= s1_p_d;
         s1_clear_q   <= s1_clear_d;
         s1_last_q    <= s1_last_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         group_done_q <= group_done_d;
         out_valid_q  <= out_valid_d;
         acc_out_q    <= acc_out_d;
         cnt_out_q    <= cnt_out_d;
         ovf_out_q    <= ovf_out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_out_q;
   assign cnt_out   = cnt_out_q;
   assign ovf_out   = ovf_out_q;

endmodule

// File: tb/tb_csa_mac_accumulator.sv
// Bench for csa_mac_accumulator: directed scenarios plus randomized groups scored
// against an integer-arithmetic model of group sums.
module tb_csa_mac_accumulator;
   localparam int N     = 5;
   localparam int M     = 5;
   localparam int P     = N + M;
   localparam int ACC_W = 12;
   localparam int CNT_W = 8;
   localparam int HI    = (1 << (ACC_W - 1)) - 1;
   localparam int LO    = -(1 << (ACC_W - 1));
   localparam int RANGE = 1 << ACC_W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [P-1:0]     pp1 = '0;
   logic [P-1:0]     pp2 = '0;
   logic             in_clear = 1'b0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] cnt_out;
   logic             ovf_out;

   csa_mac_accumulator #(.N(N), .M(M), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pp1(pp1), .pp2(pp2), .in_clear(in_clear), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .cnt_out(cnt_out), .ovf_out(ovf_out));

   always #5 clk = ~clk;

   typedef struct {
      int acc;
      int cnt;
      bit ovf;
   } res_t;

   res_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_run = 0;
   int   m_cnt = 0;
   bit   m_ovf = 1'b0;
   bit   m_done = 1'b1;

   bit   s_ov, s_ovf, s_irdy;
   int   s_acc, s_cnt;

   task automatic model_reset();
      q.delete();
      m_run = 0; m_cnt = 0; m_ovf = 1'b0; m_done = 1'b1;
   endtask

   // Reference: running signed integer sum, wrapped into ACC_W bits after each add.
   task automatic model_beat(input int a, input int b, input bit c, input bit l);
      logic [P-1:0] s;
      int pv;
      res_t r;
      s  = P'(a) + P'(b);
      pv = int'($signed(s));
      if (c || m_done) begin
         m_run = 0; m_cnt = 0; m_ovf = 1'b0;
      end
      m_run = m_run + pv;
      if (m_run > HI) begin m_ovf = 1'b1; m_run = m_run - RANGE; end
      else if (m_run < LO) begin m_ovf = 1'b1; m_run = m_run + RANGE; end
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (l) begin
         r.acc = m_run; r.cnt = m_cnt; r.ovf = m_ovf;
         q.push_back(r);
         m_done = 1'b1;
      end else begin
         m_done = 1'b0;
      end
   endtask

   // One clock: drive at negedge, sample, score any output handshake, then pass the edge.
   task automatic step(input bit v, input int a, input int b, input bit c, input bit l,
                       input bit ordy, output bit ok);
      res_t e;
      @(negedge clk);
      in_valid = v; pp1 = P'(a); pp2 = P'(b); in_clear = c; in_last = l; out_ready = ordy;
      #1;
      s_ov = out_valid; s_acc = int'($signed(acc_out)); s_cnt = int'(cnt_out);
      s_ovf = ovf_out; s_irdy = in_ready;
      ok = v && in_ready;
      if (out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_extra: got acc=%0d cnt=%0d ovf=%0b, no result expected",
                     s_acc, s_cnt, s_ovf);
         end else begin
            e = q.pop_front();
            if (s_acc !== e.acc || s_cnt !== e.cnt || s_ovf !== e.ovf) begin
               failures++;
               $display("FAIL scoreboard: got acc=%0d cnt=%0d ovf=%0b, want acc=%0d cnt=%0d ovf=%0b",
                        s_acc, s_cnt, s_ovf, e.acc, e.cnt, e.ovf);
            end
         end
      end
      if (ok) model_beat(a, b, c, l);
      @(posedge clk);
   endtask

   // mode 0: out_ready low, 1: high, 2: random with input bubbles.
   task automatic send(input int a, input int b, input bit c, input bit l, input int mode);
      bit ok, dummy;
      int n;
      ok = 1'b0; n = 0;
      while (!ok && n < 50) begin
         if (mode == 2 && $urandom_range(3) == 0)
            step(1'b0, 0, 0, 1'b0, 1'b0, 1'($urandom_range(1)), dummy);
         else
            step(1'b1, a, b, c, l, mode == 2 ? 1'($urandom_range(1)) : (mode == 1), ok);
         n++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_timeout: accepted=0 want accepted=1");
      end
   endtask

   task automatic wait_res();
      bit dummy;
      int n;
      n = 0;
      do begin
         step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, dummy);
         n++;
      end while (!s_ov && n < 20);
      if (!s_ov) begin
         checks++; failures++;
         $display("FAIL result_timeout: out_valid=0 want 1");
      end
   endtask

   task automatic consume();
      bit dummy;
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, dummy);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || acc_out !== '0 || cnt_out !== '0 || ovf_out !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: ov=%0b acc=%0d cnt=%0d ovf=%0b irdy=%0b want 0 0 0 0 1",
                  out_valid, acc_out, cnt_out, ovf_out, in_ready);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single_beat();
      bit dummy;
      send(100, 156, 1'b1, 1'b1, 0);
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, dummy);
      checks++;
      if (s_ov !== 1'b0) begin
         failures++; $display("FAIL latency_early: out_valid=%0b want 0", s_ov);
      end
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, dummy);
      checks++;
      if (s_ov !== 1'b1 || s_acc !== 256 || s_cnt !== 1 || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL single_beat: ov=%0b acc=%0d cnt=%0d ovf=%0b want 1 256 1 0", s_ov, s_acc, s_cnt, s_ovf);
      end
      consume();
   endtask

   task automatic test_group3();
      send(-300, 44, 1'b1, 1'b0, 0);
      send(10, 5, 1'b0, 1'b0, 0);
      send(0, -1, 1'b0, 1'b1, 0);
      wait_res();
      checks++;
      if (s_acc !== -242 || s_cnt !== 3 || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL group3: acc=%0d cnt=%0d ovf=%0b want -242 3 0", s_acc, s_cnt, s_ovf);
      end
      consume();
   endtask

   task automatic test_redundant_wrap();
      send(400, 400, 1'b1, 1'b1, 0);
      wait_res();
      checks++;
      if (s_acc !== -224 || s_cnt !== 1) begin
         failures++;
         $display("FAIL redundant_wrap: acc=%0d cnt=%0d want -224 1", s_acc, s_cnt);
      end
      consume();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) send(511, 0, i == 0, i == 4, 0);
      wait_res();
      checks++;
      if (s_acc !== -1541 || s_cnt !== 5 || s_ovf !== 1'b1) begin
         failures++;
         $display("FAIL overflow: acc=%0d cnt=%0d ovf=%0b want -1541 5 1", s_acc, s_cnt, s_ovf);
      end
      consume();
      send(5, 0, 1'b0, 1'b1, 0);
      wait_res();
      checks++;
      if (s_acc !== 5 || s_cnt !== 1 || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL overflow_cleared: acc=%0d cnt=%0d ovf=%0b want 5 1 0", s_acc, s_cnt, s_ovf);
      end
      consume();
   endtask

   task automatic test_mid_clear();
      send(50, 0, 1'b1, 1'b0, 0);
      send(60, 0, 1'b0, 1'b0, 0);
      send(7, 0, 1'b1, 1'b0, 0);
      send(3, 0, 1'b0, 1'b1, 0);
      wait_res();
      checks++;
      if (s_acc !== 10 || s_cnt !== 2 || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL mid_clear: acc=%0d cnt=%0d ovf=%0b want 10 2 0", s_acc, s_cnt, s_ovf);
      end
      consume();
   endtask

   task automatic test_cnt_saturate();
      for (int i = 0; i < 300; i++) send(1, 0, i == 0, i == 299, 0);
      wait_res();
      checks++;
      if (s_acc !== 300 || s_cnt !== CMAX || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL cnt_saturate: acc=%0d cnt=%0d ovf=%0b want 300 %0d 0", s_acc, s_cnt, s_ovf, CMAX);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      bit ok;
      send(7, 0, 1'b1, 1'b1, 0);
      send(20, 0, 1'b1, 1'b0, 0);
      send(-5, 0, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 9, 0, 1'b1, 1'b1, 1'b0, ok);
         checks++;
         if (ok !== 1'b0 || s_irdy !== 1'b0 || s_ov !== 1'b1 || s_acc !== 7) begin
            failures++;
            $display("FAIL stall: accepted=%0b irdy=%0b ov=%0b acc=%0d want 0 0 1 7", ok, s_irdy, s_ov, s_acc);
         end
      end
      step(1'b1, 9, 0, 1'b1, 1'b1, 1'b1, ok);
      checks++;
      if (ok !== 1'b1) begin
         failures++; $display("FAIL stall_release: accepted=%0b want 1", ok);
      end
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, ok);
      checks++;
      if (s_ov !== 1'b1 || s_acc !== 15 || s_cnt !== 2) begin
         failures++;
         $display("FAIL second_result: ov=%0b acc=%0d cnt=%0d want 1 15 2", s_ov, s_acc, s_cnt);
      end
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, ok);
      checks++;
      if (s_ov !== 1'b1 || s_acc !== 9 || s_cnt !== 1) begin
         failures++;
         $display("FAIL third_result: ov=%0b acc=%0d cnt=%0d want 1 9 1", s_ov, s_acc, s_cnt);
      end
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, ok);
      checks++;
      if (s_ov !== 1'b0) begin
         failures++; $display("FAIL drained: out_valid=%0b want 0", s_ov);
      end
   endtask

   task automatic test_async_reset();
      bit dummy;
      send(33, 0, 1'b1, 1'b1, 0);
      send(4, 0, 1'b1, 1'b0, 0);
      send(8, 0, 1'b0, 1'b0, 0);
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, dummy);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || acc_out !== '0 || cnt_out !== '0 || ovf_out !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: ov=%0b acc=%0d cnt=%0d ovf=%0b irdy=%0b want 0 0 0 0 1",
                  out_valid, acc_out, cnt_out, ovf_out, in_ready);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(6, 0, 1'b0, 1'b1, 0);
      wait_res();
      checks++;
      if (s_acc !== 6 || s_cnt !== 1 || s_ovf !== 1'b0) begin
         failures++;
         $display("FAIL after_reset: acc=%0d cnt=%0d ovf=%0b want 6 1 0", s_acc, s_cnt, s_ovf);
      end
      consume();
   endtask

   task automatic test_random();
      int len;
      for (int g = 0; g < 1000; g++) begin
         len = $urandom_range(6, 1);
         for (int i = 0; i < len; i++)
            send(int'($urandom_range(RANGE / 4 - 1)) - 128 + int'($urandom_range(1 << P) % (1 << P)),
                 int'($urandom_range((1 << P) - 1)),
                 (i == 0) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0),
                 i == len - 1, 2);
      end
      for (int i = 0; i < 20; i++) consume();
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL random_drain: pending=%0d want 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_group3();
      test_redundant_wrap();
      test_overflow();
      test_mid_clear();
      test_cnt_saturate();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
